nibble_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer built around a single existing fa4 4-bit ripple adder instance.
- Adds or subtracts two WIDTH-bit operands one nibble per cycle, LSB nibble first, holding the carry in a register between nibbles.
- Sits between a requester issuing operand pairs and a consumer taking results; both sides use valid/ready handshakes.

---
 rtl/nibble_add_seq_pkg.sv | 21 ++
 rtl/nibble_add_seq_fa4.sv | 26 ++
 rtl/nibble_add_seq.sv | 116 +++++++++++
 tb/tb_nibble_add_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nibble_add_seq_pkg.sv
// nibble_add_seq_pkg : shared FSM encoding, nibble width and counter sizing.
// Revision 1.0
`default_nettype none

package nibble_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_add_seq_fa4.sv
// fa4 : 4-bit ripple-carry adder built from four full-adder cells.
// Revision 1.0
`default_nettype none

module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_add_seq.sv
// nibble_add_seq : WIDTH-bit add/subtract, one nibble per cycle through a shared fa4.
// Revision 1.0
`default_nettype none

module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  input  logic             sub_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt, b_eff;
  logic             a_msb, b_msb;
  logic [3:0]       fa_sum;
  logic             fa_cout;
  logic             last;

  fa4 u_fa4 (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign b_eff = sub_in ? ~b_in : b_in;
  assign last  = (cnt == LAST);

  // New nibble enters at the top so the LSB nibble lands at the bottom after NIB shifts.
  if (NIB > 1) begin : g_multi
    assign res_nxt = {fa_sum, res[WIDTH-1:NIBBLE_W]};
  end else begin : g_single
    assign res_nxt = fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      ovf_out  <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      a_sh  <= a_in;
      b_sh  <= b_eff;
      carry <= sub_in ? 1'b1 : cin_in;
      a_msb <= a_in[WIDTH-1];
      b_msb <= b_eff[WIDTH-1];
      cnt   <= '0;
    end else if (state == RUN) begin
      res   <= res_nxt;
      carry <= fa_cout;
      a_sh  <= a_sh >> NIBBLE_W;
      b_sh  <= b_sh >> NIBBLE_W;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum_out  <= res_nxt;
        cout_out <= fa_cout;
        ovf_out  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq : vector table plus scoreboard for nibble_add_seq.
// Revision 1.0
`default_nettype none

module tb_nibble_add_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int NV    = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] a_in, b_in;
  logic             cin_in, sub_in;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out, ovf_out;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl [NV];
  vec_t sb [$];
  vec_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .sub_in    (sub_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Retire side: every handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {31'b0, res_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sum",  {16'b0, sum_out}, {16'b0, mon_e.sum});
        chk("cout", {31'b0, cout_out}, {31'b0, mon_e.cout});
        chk("ovf",  {31'b0, ovf_out},  {31'b0, mon_e.ovf});
      end
    end
  end

  // Returns at the negedge where res_valid is first seen high.
  task automatic send(input vec_t v);
    int g;
    int cyc;
    @(negedge clk);
    a_in = v.a; b_in = v.b; cin_in = v.cin; sub_in = v.sub; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 100) begin @(negedge clk); g++; end
    chk("accept_wait", {31'b0, req_ready}, 32'd1);
    sb.push_back(v);
    @(negedge clk);
    req_valid = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom); cin_in = 1'($urandom); sub_in = 1'($urandom);
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    cyc = 0;
    while (!res_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("latency", cyc, NIB);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin @(negedge clk); g++; end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h000D, 1'b1, 1'b1, 16'hFFF8, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_sum",       {16'b0, sum_out},   32'd0);
    chk("rst_cout",      {31'b0, cout_out},  32'd0);
    chk("rst_ovf",       {31'b0, ovf_out},   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      send(tbl[i]);
      drain();
    end
    @(negedge clk);
    chk("hold_sum",       {16'b0, sum_out}, {16'b0, tbl[NV-1].sum});
    chk("idle_res_valid", {31'b0, res_valid}, 32'd0);

    // Backpressure: result parked in DONE while new requests are offered.
    res_ready = 1'b0;
    send(tbl[3]);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_sum",       {16'b0, sum_out},   32'h8000);
      chk("bp_ovf",       {31'b0, ovf_out},   32'd1);
      req_valid = (i % 2 == 0);
      a_in = 16'h0F0F; b_in = 16'h0101; sub_in = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 res_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_after_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_after_res_valid", {31'b0, res_valid}, 32'd0);

    // Reset during the second nibble.
    @(negedge clk);
    a_in = 16'hAAAA; b_in = 16'h5555; cin_in = 1'b0; sub_in = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("midrst_sum",       {16'b0, sum_out},   32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_cout",      {31'b0, cout_out},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(tbl[4]);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
